// File: rtl/xb_iport_arb_pkg.sv
// Shared definitions for the crossbar input-port stage (package xb_pkg):
// default VC count / flit width, a clog2 helper and the lock-FSM encoding.
package xb_pkg;

  localparam int V_DEF  = 4;
  localparam int DW_DEF = 32;

  // Width needed to hold values 0..n-1 (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/xb_iport_arb_if.sv
// Bundle of VC-side and output-side signals of one crossbar input port.
//
// Handshake: the output stage offers a flit while out_valid=1; the flit is
// taken on a rising clk edge where out_valid=1 and out_ready=1. VC buffers
// offer a flit while vc_valid[i]=1 and dequeue it on an edge where
// vc_pop[i]=1; vc_pop is only ever raised for a VC whose vc_valid is high.
interface xb_iport_arb_if #(
  parameter int V  = xb_pkg::V_DEF,
  parameter int DW = xb_pkg::DW_DEF
);
  import xb_pkg::*;

  localparam int VW = clog2(V);

  logic [V-1:0]    vc_valid;
  logic [V*DW-1:0] vc_data;
  logic [V-1:0]    vc_tail;
  logic [V-1:0]    vc_pop;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [VW-1:0]   out_vc;
  logic            out_tail;
  logic            out_ready;

  // Environment side: VC buffers upstream and the main stage downstream.
  modport master (
    output vc_valid, vc_data, vc_tail, out_ready,
    input  vc_pop, out_valid, out_data, out_vc, out_tail
  );

  // Arbiter side.
  modport slave (
    input  vc_valid, vc_data, vc_tail, out_ready,
    output vc_pop, out_valid, out_data, out_vc, out_tail
  );

endinterface

// File: rtl/xb_iport_arb_rr.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping from N-1 back to 0. The pointer register is kept by the caller.
module rr_arb
  import xb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic [clog2(N)-1:0]   gnt_id
);

  localparam int IW = clog2(N);

  logic found;
  int   idx;

  // Scan N positions starting at ptr and take the first requester.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/xb_iport_arb.sv
// Input-port stage of the crossbar: round-robin selection among V VCs and a
// one-deep registered output stage with valid/ready handshake.
// Optional per-packet grant locking is compiled in with XB_IPORT_PKT_LOCK_EN;
// without it arbitration happens every flit and flits of VCs interleave.
// dbg_state / dbg_ptr expose the lock FSM state and round-robin pointer.
module xb_iport_arb
  import xb_pkg::*;
#(
  parameter int V  = V_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  xb_iport_arb_if.slave         bus,
  output lock_state_t           dbg_state,
  output logic [clog2(V)-1:0]   dbg_ptr
);

  localparam int VW = clog2(V);

  logic [VW-1:0] ptr_q;
  logic [VW-1:0] ptr_nxt;
  logic [V-1:0]  req;
  logic [V-1:0]  gnt;
  logic [VW-1:0] gnt_id;
  logic          load;
  logic          unit_done;
  logic          g_tail;
  logic [DW-1:0] g_data;

`ifdef XB_IPORT_PKT_LOCK_EN
  lock_state_t   state_q, state_d;
  logic [VW-1:0] lock_vc_q, lock_vc_d;

  // While a packet holds the port only its VC may request.
  always_comb begin
    req = bus.vc_valid;
    if (state_q == ST_LOCKED) req = bus.vc_valid & (V'(1) << lock_vc_q);
  end

  // Lock FSM register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lock_vc_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
    end
  end

  // Lock on a non-tail grant from IDLE, release on the tail grant.
  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    case (state_q)
      ST_IDLE: begin
        if (load && !g_tail) begin
          state_d   = ST_LOCKED;
          lock_vc_d = gnt_id;
        end
      end
      ST_LOCKED: begin
        if (load && g_tail) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign unit_done = load && g_tail;
  assign dbg_state = state_q;
`else
  assign req       = bus.vc_valid;
  assign unit_done = load;
  assign dbg_state = ST_IDLE;
`endif

  rr_arb #(.N(V)) u_rr (
    .req    (req),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // A flit moves in when something requests and the output slot is free or
  // draining this same cycle; reset blocks any pop.
  assign load       = (|req) && (!bus.out_valid || bus.out_ready) && !rst;
  assign bus.vc_pop = load ? gnt : '0;
  assign g_tail     = bus.vc_tail[gnt_id];
  assign g_data     = bus.vc_data[gnt_id*DW +: DW];
  assign ptr_nxt    = (gnt_id == VW'(V - 1)) ? '0 : gnt_id + 1'b1;
  assign dbg_ptr    = ptr_q;

  // Round-robin pointer moves past the winner when its unit completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else if (unit_done) ptr_q <= ptr_nxt;
  end

  // One-deep output stage: load wins over drain, data holds when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_vc    <= '0;
      bus.out_tail  <= 1'b0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= g_data;
      bus.out_vc    <= gnt_id;
      bus.out_tail  <= g_tail;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xb_iport_arb.sv
// Directed bench for xb_iport_arb: a V=4 instance driven from vector tables
// and a V=8 instance for the sparse wrap-around case.
module tb_xb_iport_arb;
  import xb_pkg::*;

  logic clk;
  logic rst;

  xb_iport_arb_if #(.V(4), .DW(32)) bus4 ();
  xb_iport_arb_if #(.V(8), .DW(32)) bus8 ();

  lock_state_t st4, st8;
  logic [1:0]  ptr4;
  logic [2:0]  ptr8;

  xb_iport_arb #(.V(4), .DW(32)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .dbg_state(st4), .dbg_ptr(ptr4)
  );

  xb_iport_arb #(.V(8), .DW(32)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .dbg_state(st8), .dbg_ptr(ptr8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] tail;
    logic       ready;
    logic [3:0] pop;
    logic       ov;
    logic [1:0] vc;
    logic       otail;
    logic [1:0] ptr;
    logic       st;
  } vec_t;

  vec_t seq_a[$];
  vec_t seq_b[$];

  int n_pass;
  int n_total;
  int cur_row;

  function automatic logic [31:0] data_of(input int i);
    return 32'h1357_9BDF * 32'(i + 1);
  endfunction

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] tail,
                              input logic ready, input logic [3:0] pop,
                              input logic ov, input logic [1:0] vc,
                              input logic otail, input logic [1:0] ptr,
                              input logic st);
    vec_t v;
    v.valid = valid; v.tail = tail; v.ready = ready; v.pop = pop;
    v.ov = ov; v.vc = vc; v.otail = otail; v.ptr = ptr; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s row %0d: got %0h expected %0h", name, cur_row, act, exp);
    else
      n_pass++;
  endtask

  // Called at posedge+1: drive, check pop at the falling edge, then check
  // the registered outputs one step after the next rising edge.
  task automatic apply_vec(input vec_t v);
    bus4.vc_valid  = v.valid;
    bus4.vc_tail   = v.tail;
    bus4.out_ready = v.ready;
    #4;
    chk("vc_pop", 64'(bus4.vc_pop), 64'(v.pop));
    @(posedge clk);
    #1;
    chk("out_valid", 64'(bus4.out_valid), 64'(v.ov));
    chk("out_vc", 64'(bus4.out_vc), 64'(v.vc));
    chk("out_tail", 64'(bus4.out_tail), 64'(v.otail));
    chk("out_data", 64'(bus4.out_data), 64'(data_of(int'(v.vc))));
    chk("ptr", 64'(ptr4), 64'(v.ptr));
    chk("state", 64'(st4), 64'(v.st));
  endtask

  task automatic step8(input logic [7:0] valid, input logic [7:0] pop,
                       input logic [2:0] vc, input logic [2:0] ptr);
    bus8.vc_valid = valid;
    #4;
    chk("v8_pop", 64'(bus8.vc_pop), 64'(pop));
    @(posedge clk);
    #1;
    chk("v8_out_valid", 64'(bus8.out_valid), 64'(1'b1));
    chk("v8_out_vc", 64'(bus8.out_vc), 64'(vc));
    chk("v8_out_data", 64'(bus8.out_data), 64'(data_of(int'(vc))));
    chk("v8_ptr", 64'(ptr8), 64'(ptr));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    cur_row = -1;

    // Vector tables (single-flit packets unless a tail bit is cleared).
    // Fairness, backpressure with same-cycle reload, drain, idle.
    seq_a.push_back(mk(4'hF, 4'hF, 1, 4'b0001, 1, 0, 1, 1, 0));
    seq_a.push_back(mk(4'hF, 4'hF, 1, 4'b0010, 1, 1, 1, 2, 0));
    seq_a.push_back(mk(4'hF, 4'hF, 1, 4'b0100, 1, 2, 1, 3, 0));
    seq_a.push_back(mk(4'hF, 4'hF, 1, 4'b1000, 1, 3, 1, 0, 0));
    seq_a.push_back(mk(4'hF, 4'hF, 1, 4'b0001, 1, 0, 1, 1, 0));
    for (int i = 0; i < 3; i++)
      seq_a.push_back(mk(4'hF, 4'hF, 0, 4'b0000, 1, 0, 1, 1, 0));
    seq_a.push_back(mk(4'hF, 4'hF, 1, 4'b0010, 1, 1, 1, 2, 0));
    seq_a.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 0, 1, 1, 2, 0));
    seq_a.push_back(mk(4'h0, 4'hF, 0, 4'b0000, 0, 1, 1, 2, 0));

    // After reset: VC0 first, VC1 alone to put ptr at 2, then VC2 sends a
    // 3-flit packet while VC0/VC1 are also valid.
    seq_b.push_back(mk(4'hF, 4'hF, 1, 4'b0001, 1, 0, 1, 1, 0));
    seq_b.push_back(mk(4'b0010, 4'hF, 1, 4'b0010, 1, 1, 1, 2, 0));
`ifdef XB_IPORT_PKT_LOCK_EN
    seq_b.push_back(mk(4'b0111, 4'b0011, 1, 4'b0100, 1, 2, 0, 2, 1));
    seq_b.push_back(mk(4'b0111, 4'b0011, 1, 4'b0100, 1, 2, 0, 2, 1));
    seq_b.push_back(mk(4'b0111, 4'b0111, 1, 4'b0100, 1, 2, 1, 3, 0));
    seq_b.push_back(mk(4'b0011, 4'b0011, 1, 4'b0001, 1, 0, 1, 1, 0));
`else
    seq_b.push_back(mk(4'b0111, 4'b0011, 1, 4'b0100, 1, 2, 0, 3, 0));
    seq_b.push_back(mk(4'b0111, 4'b0011, 1, 4'b0001, 1, 0, 1, 1, 0));
    seq_b.push_back(mk(4'b0111, 4'b0111, 1, 4'b0010, 1, 1, 1, 2, 0));
    seq_b.push_back(mk(4'b0011, 4'b0011, 1, 4'b0001, 1, 0, 1, 1, 0));
`endif
    seq_b.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 0, 0, 1, 1, 0));

    // Power-on reset with every VC requesting.
    rst = 1'b1;
    bus4.vc_valid = 4'hF; bus4.vc_tail = 4'hF; bus4.out_ready = 1'b1;
    bus8.vc_valid = 8'h00; bus8.vc_tail = 8'hFF; bus8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) bus4.vc_data[i*32 +: 32] = data_of(i);
    for (int i = 0; i < 8; i++) bus8.vc_data[i*32 +: 32] = data_of(i);
    #12;
    chk("rst_pop", 64'(bus4.vc_pop), 64'(0));
    chk("rst_out_valid", 64'(bus4.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus4.out_data), 64'(0));
    chk("rst_out_vc", 64'(bus4.out_vc), 64'(0));
    chk("rst_out_tail", 64'(bus4.out_tail), 64'(0));
    chk("rst_ptr", 64'(ptr4), 64'(0));
    chk("rst_state", 64'(st4), 64'(0));
    bus4.vc_valid = 4'h0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < seq_a.size(); i++) begin
      cur_row = i;
      apply_vec(seq_a[i]);
    end

    // Fill the output stage, hold it, then reset asynchronously mid-cycle.
    cur_row = 100;
    apply_vec(mk(4'hF, 4'hF, 1, 4'b0100, 1, 2, 1, 3, 0));
    bus4.out_ready = 1'b0;
    #2 rst = 1'b1;
    bus4.out_ready = 1'b1;
    #1;
    chk("mid_rst_pop", 64'(bus4.vc_pop), 64'(0));
    chk("mid_rst_out_valid", 64'(bus4.out_valid), 64'(0));
    chk("mid_rst_out_data", 64'(bus4.out_data), 64'(0));
    chk("mid_rst_out_vc", 64'(bus4.out_vc), 64'(0));
    chk("mid_rst_out_tail", 64'(bus4.out_tail), 64'(0));
    chk("mid_rst_ptr", 64'(ptr4), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < seq_b.size(); i++) begin
      cur_row = 200 + i;
      apply_vec(seq_b[i]);
    end

    // V=8 sparse wrap: VC6 alone sets ptr=7, then only VC7 and VC0 request.
    cur_row = 300;
    step8(8'h40, 8'h40, 3'd6, 3'd7);
    cur_row = 301;
    step8(8'h81, 8'h80, 3'd7, 3'd0);
    cur_row = 302;
    step8(8'h81, 8'h01, 3'd0, 3'd1);
    cur_row = 303;
    step8(8'h81, 8'h80, 3'd7, 3'd0);
    bus8.vc_valid = 8'h00;
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xb_iport_arb.md
# xb_iport_arb

Parametrised input-port stage of the crossbar for the two-stage switch-allocation router. It arbitrates locally among the V virtual channels of one input port with a round-robin policy and registers the winning flit, its VC id and a valid flag into a one-deep output stage. That stage feeds the main crossbar and allocator through a valid/ready handshake. The block replaces the fixed four-VC, externally-selected multiplexer: selection is now internal and fair, the output is registered, and per-packet grant locking is optional.

## Interface
Parameters:
- V, 4, number of VCs per input port (≥2)
- DW, 32, flit data width
- VW, $clog2(V), VC id width (derived, not overridden)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- vc_valid  in  V  bit i: VC i buffer holds a flit ready to leave
- vc_data  in  V*DW  flit of VC i at bits [i*DW +: DW]
- vc_tail  in  V  bit i: current flit of VC i is a tail (or single-flit packet)
- vc_pop  out  V  one-hot or zero; dequeue strobe to VC i buffer
- out_valid  out  1  output register holds a flit
- out_data  out  DW  registered flit
- out_vc  out  VW  VC id of registered flit
- out_tail  out  1  registered tail flag
- out_ready  in  1  main stage accepts flit this cycle

## Operation
- Load condition: `load = |req && (!out_valid || out_ready)`. The request vector `req` is `vc_valid`, or `vc_valid & lock_mask` when locked.
- On load:
  - winner g = round-robin pick of `req`, starting from pointer `ptr`.
  - `vc_pop[g]` = 1 combinationally in the same cycle.
  - out_data/out_vc/out_tail capture `vc_data[g]`, g, `vc_tail[g]`.
  - out_valid ← 1.
- Otherwise, if `out_ready && out_valid`, then out_valid ← 0. The data registers hold their value.
- vc_pop is never asserted for a VC whose vc_valid is 0. At most one bit is set.
- Pointer update: on a grant that completes an arbitration unit, `ptr ← (g+1) mod V`. The arbitration unit is the flit, or the packet when lock mode is compiled in. Wrap from V-1 to 0 is required.
- Lock FSM, when compiled in:
  - IDLE→LOCKED on load with `vc_tail[g]=0`; store `lock_vc ← g`.
  - LOCKED: `req` is masked to `lock_vc` only. Other VCs stall even if valid.
  - LOCKED→IDLE on load with `vc_tail[lock_vc]=1`.
  - A head-and-tail flit in IDLE stays in IDLE.
- Simultaneous drain and load: both happen in the same cycle, sustaining 1 flit/cycle.
- Reset mid-packet: the FSM returns to IDLE, lock is dropped, ptr returns to 0, and the output register empties. Upstream buffer recovery is outside this block.

## Timing
- Reset values: out_valid=0, out_data=0, out_vc=0, out_tail=0, ptr=0, state IDLE, lock_vc=0. vc_pop=0 while rst is high.
- Latency: a flit popped in cycle n is visible on out_* in cycle n+1.
- Throughput: 1 flit/cycle while out_ready stays high.
- Backpressure: when out_valid=1 and out_ready=0, out_* are stable and vc_pop=0.
- vc_pop depends combinationally on vc_valid and out_ready. There is no combinational path from vc_data to any output.

## Configuration
- `XB_IPORT_PKT_LOCK_EN` defined: the lock FSM is present.
  - A VC keeps the port from head through tail.
  - ptr advances only on the tail grant.
  - Packets leave the port non-interleaved.
- Undefined: no FSM and no lock_vc register.
  - Arbitration happens every flit and ptr advances on every grant.
  - Flits of different VCs interleave.
  - vc_tail is passed through to out_tail only.

## Structure
- Shared package xb_pkg holds:
  - defaults for V and DW;
  - a clog2 helper;
  - lock-FSM state encoding (IDLE=0, LOCKED=1).
- Sub-module `rr_arb` #(N):
  - inputs: req[N], ptr[$clog2(N)];
  - outputs: one-hot gnt[N] and binary gnt_id.
  - It is purely combinational. The pointer register lives in xb_iport_arb.

## Test plan
- Reset: assert rst asynchronously mid-cycle with vc_valid=4'b1111. Outputs are 0 immediately, vc_pop=0, and after release the first grant goes to VC0.
- Fairness: V=4, lock off, all VCs valid, out_ready=1, single-flit packets. out_vc sequence is 0,1,2,3,0, with one pop per cycle.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1. out_data/out_vc are held, vc_pop=0. When out_ready rises, the next flit loads in the same cycle.
- Lock (XB_IPORT_PKT_LOCK_EN): VC2 sends a 3-flit packet (tail on the third) while VC0 and VC1 are valid. out_vc=2,2,2 then 3-wrap order gives 0, and ptr=3 after the tail.
- Interleave (lock off): same stimulus as the lock test. out_vc alternates among valid VCs, and VC2's flits are not contiguous.
- Wrap/sparse: V=8, only VC7 and VC0 valid, ptr=7. Grants alternate 7,0,7; ptr wraps to 0 after the VC7 grant.
